// File: rtl/serial_adder_n.sv
// rtl/serial_adder_n.sv - bit-serial N-bit add/sub through a decoder-based full adder.
// Optional signed overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_n #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          c_out_q, c_out_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0]    dec;
  logic [3:0]    dec_lo;
  logic [3:0]    dec_hi;
  logic          fa_s;
  logic          fa_c;
  logic          last;

  // Decoder on {carry, b0}, split into two enabled slices by a0: one-hot minterms of {a0,carry,b0}.
  always_comb begin
    dec    = 4'b0001 << {carry_q, b_q[0]};
    dec_lo = dec & {4{~a_q[0]}};
    dec_hi = dec & {4{a_q[0]}};
    fa_s   = dec_lo[1] | dec_lo[2] | dec_hi[0] | dec_hi[3];
    fa_c   = dec_lo[3] | dec_hi[1] | dec_hi[2] | dec_hi[3];
  end

  assign last = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = mode ? ~b : b;
          carry_d = mode ? 1'b1 : c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = {fa_s, sum_q[N-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c;
        if (last) begin
          cnt_d   = '0;
          c_out_d = fa_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // On the last RUN cycle carry_q is the carry into the MSB.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && start) begin
      ovf_d = 1'b0;
    end else if (state_q == RUN && last) begin
      ovf_d = carry_q ^ fa_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// tb/tb_serial_adder_n.sv - randomized and directed checks of serial_adder_n against an arithmetic model.
module tb_serial_adder_n;

  localparam int N = 8;
`ifdef SERIAL_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         mode;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         c_out;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;

  serial_adder_n #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .c_in(c_in), .busy(busy), .done(done), .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Returns {ovf, c_out, sum} of an operation from plain integer arithmetic.
  function automatic logic [N+1:0] ref_add(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic m, input logic ci);
    logic [N-1:0] yy;
    logic         cc;
    logic [N:0]   tot;
    longint       st;
    logic         v;
    yy  = m ? ~y : y;
    cc  = m ? 1'b1 : ci;
    tot = {1'b0, x} + {1'b0, yy} + {{N{1'b0}}, cc};
    st  = longint'($signed(x)) + longint'($signed(yy)) + longint'(cc);
    v   = (st > (longint'(1) << (N - 1)) - 1) || (st < -(longint'(1) << (N - 1)));
    return {v, tot};
  endfunction

  // Model: phase 0 idle, 1..N busy, N+1 done.
  int           m_phase;
  logic [N-1:0] m_sum, p_sum;
  logic         m_cout, p_cout;
  logic         m_ovf, p_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase <= 1;
        m_ovf   <= 1'b0;
        {p_ovf, p_cout, p_sum} <= ref_add(a, b, mode, c_in);
      end
    end else if (m_phase == N + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
      if (m_phase == N) begin
        m_sum  <= p_sum;
        m_cout <= p_cout;
        m_ovf  <= OVF_ON & p_ovf;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, (m_phase >= 1 && m_phase <= N));
    chk("done", done, (m_phase == N + 1));
    chk("ovf", ovf, m_ovf);
    chk("busy_done_excl", busy & done, 1'b0);
    if (m_phase == 0 || m_phase == N + 1) begin
      chk("sum", sum, m_sum);
      chk("c_out", c_out, m_cout);
    end
  end

  task automatic start_op(input logic [N-1:0] ta, input logic [N-1:0] tb,
                          input logic tm, input logic tc);
    @(negedge clk); #2;
    a = ta; b = tb; mode = tm; c_in = tc; start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    a = N'($urandom); b = N'($urandom); mode = 1'($urandom); c_in = 1'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  logic [7:0] t_a   [7] = '{8'h5A, 8'hFF, 8'hFF, 8'h10, 8'h20, 8'h7F, 8'h40};
  logic [7:0] t_b   [7] = '{8'h3C, 8'h01, 8'h01, 8'h20, 8'h10, 8'h01, 8'h20};
  logic       t_m   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       t_c   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [7:0] t_s   [7] = '{8'h96, 8'h00, 8'h01, 8'hF0, 8'h10, 8'h80, 8'h60};
  logic       t_co  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       t_ov  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int cyc;
    int dones;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0; c_in = 1'b0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", c_out, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      start_op(t_a[i], t_b[i], t_m[i], t_c[i]);
      wait_done(cyc);
      chk($sformatf("dir%0d_latency", i), cyc, N + 1);
      chk($sformatf("dir%0d_sum", i), sum, t_s[i]);
      chk($sformatf("dir%0d_cout", i), c_out, t_co[i]);
      chk($sformatf("dir%0d_ovf", i), ovf, OVF_ON & t_ov[i]);
    end

    // Start re-presented mid-RUN and during DONE must be ignored.
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2 start = 1'b1; a = 8'h01; b = 8'h01;
    @(negedge clk); #2 start = 1'b0;
    wait_done(cyc);
    dones = int'(done);
    chk("repulse_sum", sum, 8'h96);
    #2 start = 1'b1; a = 8'h01; b = 8'h01;
    @(negedge clk);
    dones += int'(done);
    #2 start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      dones += int'(done);
    end
    chk("repulse_dones", dones, 1);
    chk("repulse_sum_hold", sum, 8'h96);

    // Reset in RUN cycle 4 aborts the operation.
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_sum", sum, 8'h00);
    chk("abort_done", done, 1'b0);
    @(negedge clk); #2 rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      dones += int'(done);
    end
    chk("abort_no_done", dones, 0);
    start_op(8'h03, 8'h04, 1'b0, 1'b0);
    wait_done(cyc);
    chk("after_abort_latency", cyc, N + 1);
    chk("after_abort_sum", sum, 8'h07);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
      wait_done(cyc);
      chk("rand_latency", cyc, N + 1);
    end
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
